// File: rtl/lcd_ctrl_pkg.sv
// Shared constants for the LCD key/mode controller: FSM state codes, key indices and the scroll wrap helper.
package lcd_ctrl_pkg;

    localparam int NUM_KEYS = 4;

    localparam int KEY_NEXT = 0;
    localparam int KEY_PREV = 1;
    localparam int KEY_CHAR = 2;
    localparam int KEY_RUN  = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    typedef logic [NUM_KEYS-1:0] key_vec_t;

    // 11-bit intermediate so val+step cannot overflow before the modulus is applied.
    function automatic logic [9:0] wrap_add(input logic [9:0] val, input logic [10:0] step,
                                            input logic [10:0] modulus);
        logic [10:0] sum;
        sum = {1'b0, val} + step;
        return 10'((sum >= modulus) ? (sum - modulus) : sum);
    endfunction

endpackage

// File: rtl/lcd_key_debounce.sv
// Single-key debouncer: active-low raw input, debounced level and a 1-cycle press pulse on a clean 1->0.
module lcd_key_debounce
    import lcd_ctrl_pkg::*;
#(
    parameter int DB_CNT = 660000
) (
    input  logic lcd_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_lvl,
    output logic press
);

    localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT - 1);

    logic          key_prev;
    logic          armed;
    logic [CW-1:0] cnt;

    // armed is set only after a stable released level, so a key held through reset never reports a press.
    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            key_prev <= 1'b1;
            cnt      <= '0;
            key_lvl  <= 1'b1;
            armed    <= 1'b0;
            press    <= 1'b0;
        end else begin
            key_prev <= key_in;
            press    <= 1'b0;
            if (key_in != key_prev) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else if (key_prev) begin
                key_lvl <= 1'b1;
                armed   <= 1'b1;
            end else if (armed && key_lvl) begin
                key_lvl <= 1'b0;
                press   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_key_mode_ctrl.sv
// Key-driven display mode / character / scroll controller; commands are applied only at lcd_vs frame boundaries.
// Optional build macro LCD_KEY_AUTOREPEAT_EN adds auto-repeat on the character key.
module lcd_key_mode_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int DB_CNT      = 660000,
    parameter int NUM_MODES   = 4,
    parameter int CHAR_MAX    = 15,
    parameter int H_RES       = 800,
    parameter int SCROLL_STEP = 2,
    parameter int VS_ACT_LOW  = 1
) (
    input  logic       lcd_clk,
    input  logic       sys_rst,
    input  logic [3:0] key,
    input  logic       lcd_vs,
    output logic [1:0] disp_mode,
    output logic [3:0] char_idx,
    output logic [9:0] scroll_x,
    output logic       running,
    output logic       frame_upd
);

    localparam logic [1:0]  MODE_MAX = 2'(NUM_MODES - 1);
    localparam logic [3:0]  CHAR_TOP = 4'(CHAR_MAX);
    localparam logic [10:0] H_MOD    = 11'(H_RES);
    localparam logic [10:0] STEP     = 11'(SCROLL_STEP);
    localparam logic        VS_RST   = (VS_ACT_LOW == 0);

    key_vec_t   key_lvl;
    key_vec_t   press;
    key_vec_t   pend;
    key_vec_t   pend_set;
    logic       vs_q;
    logic       vs_edge;
    logic       rpt_set;
    logic       unused_lvl;
    logic [1:0] state;
    logic [1:0] mode_nxt;
    logic [3:0] char_nxt;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_db
        lcd_key_debounce #(.DB_CNT(DB_CNT)) u_db (
            .lcd_clk (lcd_clk),
            .sys_rst (sys_rst),
            .key_in  (key[i]),
            .key_lvl (key_lvl[i]),
            .press   (press[i])
        );
    end

    assign unused_lvl = ^key_lvl;
    assign vs_edge    = (VS_ACT_LOW != 0) ? (vs_q & ~lcd_vs) : (~vs_q & lcd_vs);
    assign running    = (state == S_RUN);

`ifdef LCD_KEY_AUTOREPEAT_EN
    localparam logic [5:0] RPT_HOLD = 6'd30;
    logic [5:0] hold_cnt;
    logic [1:0] rpt_ph;

    // After RPT_HOLD held boundaries, every 4th boundary re-arms the character flag.
    assign rpt_set = vs_edge && !key_lvl[KEY_CHAR] && (hold_cnt == RPT_HOLD) && (rpt_ph == 2'd3);

    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hold_cnt <= '0;
            rpt_ph   <= '0;
        end else if (vs_edge) begin
            if (key_lvl[KEY_CHAR]) begin
                hold_cnt <= '0;
                rpt_ph   <= '0;
            end else if (hold_cnt != RPT_HOLD) begin
                hold_cnt <= hold_cnt + 6'd1;
            end else begin
                rpt_ph <= rpt_ph + 2'd1;
            end
        end
    end
`else
    assign rpt_set = 1'b0;
`endif

    always_comb begin
        pend_set           = press;
        pend_set[KEY_CHAR] = press[KEY_CHAR] | rpt_set;
    end

    always_comb begin
        mode_nxt = disp_mode;
        if (pend[KEY_NEXT] && !pend[KEY_PREV]) begin
            mode_nxt = (disp_mode == MODE_MAX) ? 2'd0 : disp_mode + 2'd1;
        end else if (pend[KEY_PREV] && !pend[KEY_NEXT]) begin
            mode_nxt = (disp_mode == 2'd0) ? MODE_MAX : disp_mode - 2'd1;
        end
        char_nxt = char_idx;
        if (pend[KEY_CHAR]) begin
            char_nxt = (char_idx == CHAR_TOP) ? 4'd0 : char_idx + 4'd1;
        end
    end

    // Presses landing on the boundary cycle survive into the next frame's pending set.
    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vs_q      <= VS_RST;
            pend      <= '0;
            state     <= S_IDLE;
            disp_mode <= '0;
            char_idx  <= '0;
            scroll_x  <= '0;
            frame_upd <= 1'b0;
        end else begin
            vs_q      <= lcd_vs;
            frame_upd <= 1'b0;
            if (vs_edge) begin
                frame_upd <= 1'b1;
                pend      <= pend_set;
                disp_mode <= mode_nxt;
                char_idx  <= char_nxt;
                case (state)
                    S_IDLE:  state <= S_RUN;
                    S_RUN: begin
                        if (pend[KEY_RUN]) state <= S_PAUSE;
                        else scroll_x <= wrap_add(scroll_x, STEP, H_MOD);
                    end
                    S_PAUSE: if (pend[KEY_RUN]) state <= S_RUN;
                    default: state <= S_IDLE;
                endcase
            end else begin
                pend <= pend | pend_set;
            end
        end
    end

endmodule

// File: tb/tb_lcd_key_mode_ctrl.sv
// Bench for lcd_key_mode_ctrl: frame-level behavioural model compared every cycle, plus literal spot checks.
module tb_lcd_key_mode_ctrl;

    localparam int DB    = 4;
    localparam int HR    = 16;
    localparam int STEP  = 2;
    localparam int FRAME = 64;

    logic       lcd_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       lcd_vs  = 1'b1;
    logic [3:0] key     = 4'hf;
    logic [1:0] disp_mode;
    logic [3:0] char_idx;
    logic [9:0] scroll_x;
    logic       running;
    logic       frame_upd;

    lcd_key_mode_ctrl #(
        .DB_CNT(DB), .NUM_MODES(4), .CHAR_MAX(15), .H_RES(HR), .SCROLL_STEP(STEP), .VS_ACT_LOW(1)
    ) dut (
        .lcd_clk   (lcd_clk),
        .sys_rst   (sys_rst),
        .key       (key),
        .lcd_vs    (lcd_vs),
        .disp_mode (disp_mode),
        .char_idx  (char_idx),
        .scroll_x  (scroll_x),
        .running   (running),
        .frame_upd (frame_upd)
    );

    always #5 lcd_clk = ~lcd_clk;

    // Frame timing: vsync low for phases 0..3 of every 64-cycle frame.
    int cyc = 0;
    initial forever begin
        @(posedge lcd_clk);
        #1;
        cyc++;
        lcd_vs = (cyc % FRAME) >= 4;
    end

    int n_pass  = 0;
    int n_total = 0;

    int m_req[4] = '{0, 0, 0, 0};
    int key2_hold = 0;

    int   m_ack[4] = '{0, 0, 0, 0};
    int   m_mode = 0, m_char = 0, m_scroll = 0;
    int   m_started = 0, m_run = 0, m_upd = 0;
    int   m_hold = 0, m_rpt = 0;
    logic m_prev_rst = 1'b1;

    // Frame-level model: at a boundary every key pressed since the last one takes effect once.
    always @(posedge lcd_clk) begin
        int p[4];
        int bnd;
        bnd = (!sys_rst && !m_prev_rst && cyc > 0 && (cyc % FRAME) == 0) ? 1 : 0;
        if (sys_rst) begin
            for (int k = 0; k < 4; k++) m_ack[k] = m_req[k];
            m_mode = 0; m_char = 0; m_scroll = 0;
            m_started = 0; m_run = 0; m_upd = 0; m_hold = 0; m_rpt = 0;
        end else begin
            m_upd = bnd;
            if (bnd != 0) begin
                for (int k = 0; k < 4; k++) begin
                    p[k] = (m_req[k] != m_ack[k]) ? 1 : 0;
                    m_ack[k] = m_req[k];
                end
`ifdef LCD_KEY_AUTOREPEAT_EN
                if (m_rpt != 0) p[2] = 1;
`endif
                if (p[0] != p[1]) m_mode = p[0] ? (m_mode + 1) % 4 : (m_mode + 3) % 4;
                if (p[2] != 0) m_char = (m_char + 1) % 16;
                if (m_started == 0) begin
                    m_started = 1;
                    m_run = 1;
                end else if (p[3] != 0) begin
                    m_run = 1 - m_run;
                end else if (m_run != 0) begin
                    m_scroll = (m_scroll + STEP) % HR;
                end
`ifdef LCD_KEY_AUTOREPEAT_EN
                m_hold = (key2_hold != 0) ? m_hold + 1 : 0;
                m_rpt  = (m_hold > 30 && ((m_hold - 30) % 4) == 0) ? 1 : 0;
`endif
            end
        end
        m_prev_rst = sys_rst;
    end

    task automatic compare_loop();
        forever begin
            logic [17:0] got;
            logic [17:0] exp;
            @(negedge lcd_clk);
            got = {disp_mode, char_idx, scroll_x, running, frame_upd};
            if (sys_rst) exp = '0;
            else exp = {2'(m_mode), 4'(m_char), 10'(m_scroll), 1'(m_run), 1'(m_upd)};
            n_total++;
            if (got === exp) n_pass++;
            else $display("FAIL outputs @cyc %0d got mode=%0d char=%0d scroll=%0d run=%0d upd=%0d expected %h",
                          cyc, got[17:16], got[15:12], got[11:2], got[1], got[0], exp);
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d expected %0d", name, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge lcd_clk);
        #2;
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        do begin
            @(posedge lcd_clk);
            #2;
            n++;
        end while ((cyc % FRAME) != p && n < 200);
        if (n >= 200) begin
            n_total++;
            $display("FAIL wait_phase timeout got cyc %0d expected phase %0d", cyc, p);
            $display("%0d/%0d checks passed", n_pass, n_total);
            $fatal(1, "timeout");
        end
    endtask

    task automatic press_key(input int k);
        key[k] = 1'b0;
        step(8);
        m_req[k]++;
        key[k] = 1'b1;
        step(8);
    endtask

    initial begin
        step(2);
        fork
            compare_loop();
        join_none
        step(8);
        check("rst_mode", disp_mode, 0);
        check("rst_char", char_idx, 0);
        check("rst_scroll", scroll_x, 0);
        check("rst_running", running, 0);
        check("rst_upd", frame_upd, 0);
        sys_rst = 1'b0;

        // First boundary starts the run; scroll steps on the following ones.
        wait_phase(1);
        check("t1_running", running, 1);
        check("t1_upd_pulse", frame_upd, 1);
        check("t1_scroll0", scroll_x, 0);
        step(1);
        check("t1_upd_low", frame_upd, 0);
        wait_phase(1);
        check("t1_scroll2", scroll_x, 2);
        wait_phase(1);
        check("t1_scroll4", scroll_x, 4);

        // Bouncing key[0]: one event, applied only at the boundary.
        wait_phase(8);
        key[0] = 1'b0; step(1);
        key[0] = 1'b1; step(1);
        key[0] = 1'b0; step(1);
        key[0] = 1'b0; step(10);
        m_req[0]++;
        key[0] = 1'b1; step(10);
        wait_phase(40);
        check("t2_mode_before", disp_mode, 0);
        wait_phase(1);
        check("t2_mode_after", disp_mode, 1);

        wait_phase(8); press_key(1);
        wait_phase(1);
        check("t3_prev_to0", disp_mode, 0);
        wait_phase(8); press_key(1);
        wait_phase(1);
        check("t3_prev_wrap", disp_mode, 3);
        wait_phase(8); press_key(0); press_key(1);
        wait_phase(1);
        check("t3_both", disp_mode, 3);

        wait_phase(8); press_key(2); press_key(2); press_key(2);
        wait_phase(1);
        check("t4_triple", char_idx, 1);
        for (int i = 0; i < 15; i++) begin
            wait_phase(8); press_key(2);
            wait_phase(1);
            check("t4_char", char_idx, (i + 2) % 16);
        end
        check("t4_scroll", scroll_x, 12);

        wait_phase(1);
        check("t5_scroll14", scroll_x, 14);
        wait_phase(8); press_key(3);
        wait_phase(1);
        check("t5_paused", running, 0);
        check("t5_hold_a", scroll_x, 14);
        wait_phase(1);
        check("t5_hold_b", scroll_x, 14);
        wait_phase(8); press_key(3);
        wait_phase(1);
        check("t5_resumed", running, 1);
        check("t5_no_step", scroll_x, 14);
        wait_phase(1);
        check("t5_wrap", scroll_x, 0);

        // Mid-frame reset with pending commands and key[1] held through it.
        wait_phase(8); press_key(0); press_key(2);
        key[1] = 1'b0;
        step(8);
        @(negedge lcd_clk); #2;
        sys_rst = 1'b1;
        #1;
        check("t6_async_mode", disp_mode, 0);
        check("t6_async_char", char_idx, 0);
        check("t6_async_scroll", scroll_x, 0);
        check("t6_async_run", running, 0);
        step(3);
        sys_rst = 1'b0;
        wait_phase(1);
        check("t6_mode_clean", disp_mode, 0);
        check("t6_char_clean", char_idx, 0);
        check("t6_run", running, 1);
        wait_phase(10);
        key[1] = 1'b1;
        wait_phase(1);
        check("t6_no_held_press", disp_mode, 0);
        check("t6_scroll", scroll_x, 2);

        // key[2] held for 40 boundaries.
        wait_phase(8);
        key[2] = 1'b0;
        step(10);
        m_req[2]++;
        key2_hold = 1;
        repeat (40) wait_phase(1);
        wait_phase(8);
        key[2] = 1'b1;
        step(10);
        key2_hold = 0;
        wait_phase(1);
`ifdef LCD_KEY_AUTOREPEAT_EN
        check("t7_hold_char", char_idx, 3);
`else
        check("t7_hold_char", char_idx, 1);
`endif
        step(4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
